// File: rtl/serial_flow_pkg.sv
// serial_flow_pkg: shared state encoding and mode constants for the serial flow ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_flow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_flow_lane.sv
// serial_flow_lane: one channel's bit-serial full adder / full subtractor slice.
// Latency: 1 cycle from an enabled a/b pair to outp; overflw updates on the last bit.
// Backpressure: none; with en low every flop holds its value.
module serial_flow_lane
  import serial_flow_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic mode,
  input  logic en,
  input  logic clr,
  input  logic last,
  output logic outp,
  output logic overflw
);

  logic cy;
  logic sum;
  logic cy_nxt;

  // Result bit and next carry (add) or next borrow (sub) for this bit position.
  always_comb begin
    sum = a ^ b ^ cy;
    if (mode == MODE_SUB) begin
      cy_nxt = (~a & b) | (~a & cy) | (b & cy);
    end else begin
      cy_nxt = (a & b) | (a & cy) | (b & cy);
    end
  end

  // Carry/borrow, result bit and final-carry flops; clr comes from a frame start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cy      <= 1'b0;
      outp    <= 1'b0;
      overflw <= 1'b0;
    end else if (clr) begin
      cy      <= 1'b0;
      overflw <= 1'b0;
    end else if (en) begin
      outp <= sum;
      cy   <= cy_nxt;
      if (last) begin
        overflw <= cy_nxt;
      end
    end
  end

endmodule

// File: rtl/serial_flow_alu.sv
// serial_flow_alu: CHANNELS parallel LSB-first bit-serial add/sub lanes over WORD_W-bit frames.
// Latency: 1 cycle from a consumed bit to outp/out_valid; done is the cycle after the last bit.
// Backpressure: none upstream; in_valid low stalls the frame with counter and carries held.
module serial_flow_alu
  import serial_flow_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WORD_W   = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [CHANNELS-1:0] line1,
  input  logic [CHANNELS-1:0] line2,
  output logic [CHANNELS-1:0] outp,
  output logic                out_valid,
  output logic [CHANNELS-1:0] overflw,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic             clr;
  logic             take;
  logic             last;

  // Abort wins over a bit arriving in the same cycle, so it also suppresses the last bit.
  assign clr  = (state == IDLE) && start;
  assign take = (state == RUN) && in_valid && !abort;
  assign last = take && (cnt == LAST_IDX);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: start only matters in IDLE, DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter, latched mode and out_valid; counter returns to 0 only outside RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      mode_q    <= MODE_ADD;
      out_valid <= 1'b0;
    end else begin
      out_valid <= take;
      if (clr) begin
        cnt    <= '0;
        mode_q <= mode;
      end else if (state != RUN) begin
        cnt <= '0;
      end else if (take && !last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    serial_flow_lane u_lane (
      .clock   (clock),
      .reset   (reset),
      .a       (line1[c]),
      .b       (line2[c]),
      .mode    (mode_q),
      .en      (take),
      .clr     (clr),
      .last    (last),
      .outp    (outp[c]),
      .overflw (overflw[c])
    );
  end

endmodule

// File: tb/tb_serial_flow_alu.sv
// tb_serial_flow_alu: directed and randomized frames against an arithmetic reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_flow_alu;

  logic       clock;
  logic       reset;
  logic       start;
  logic       mode;
  logic       abort;
  logic       in_valid;
  logic [1:0] line1;
  logic [1:0] line2;
  logic [1:0] outp;
  logic       out_valid;
  logic [1:0] overflw;
  logic       busy;
  logic       done;

  int         n_checks;
  int         n_fail;
  int         cyc;
  int         rx_n;
  int         done_cnt;
  int         done_cyc;
  logic [7:0] rx [2];
  logic [1:0] ovf_done;

  serial_flow_alu #(.CHANNELS(2), .WORD_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .abort     (abort),
    .in_valid  (in_valid),
    .line1     (line1),
    .line2     (line2),
    .outp      (outp),
    .out_valid (out_valid),
    .overflw   (overflw),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference: {carry_or_borrow, result}.
  function automatic logic [8:0] ref_op(input logic m, input logic [7:0] a, input logic [7:0] b);
    if (!m) return 9'(a) + 9'(b);
    return {(a < b) ? 1'b1 : 1'b0, 8'(a - b)};
  endfunction

  // Advance to the next falling edge and record what the DUT shows there.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (out_valid) begin
      if (rx_n < 8) begin
        rx[0][rx_n[2:0]] = outp[0];
        rx[1][rx_n[2:0]] = outp[1];
      end
      rx_n++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      ovf_done = overflw;
    end
  endtask

  task automatic idle_tick();
    in_valid = 1'b0;
    line1    = 2'($urandom);
    line2    = 2'($urandom);
    tick();
  endtask

  // cut_kind: 0 none, 1 abort while presenting bit cut_at, 2 async reset before bit cut_at.
  task automatic frame(input string nm, input logic m,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input int stall_after, input int stall_len,
                       input int cut_at, input int cut_kind,
                       input bit perturb, input bit rnd_gaps);
    logic [8:0] e0;
    logic [8:0] e1;
    logic [1:0] held_o;
    int         start_cyc;
    int         gaps;
    e0 = ref_op(m, a0, b0);
    e1 = ref_op(m, a1, b1);
    rx[0] = '0; rx[1] = '0; rx_n = 0; done_cnt = 0; gaps = 0;
    start = 1'b1; mode = m; in_valid = 1'b0; start_cyc = cyc;
    tick();
    start = 1'b0;
    check({nm, "/busy_run"}, 32'(busy), 32'd1);
    check({nm, "/ovf_clr"}, 32'(overflw), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (rnd_gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) idle_tick();
        gaps += g;
      end
      if (cut_kind == 2 && i == cut_at) begin
        #2 reset = 1'b1;
        #1;
        check({nm, "/rst_outp"}, 32'(outp), 32'd0);
        check({nm, "/rst_oval"}, 32'(out_valid), 32'd0);
        check({nm, "/rst_ovf"}, 32'(overflw), 32'd0);
        check({nm, "/rst_busy"}, 32'(busy), 32'd0);
        check({nm, "/rst_done"}, 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check({nm, "/rst_idle"}, 32'(busy), 32'd0);
        check({nm, "/rst_nodone"}, 32'(done_cnt), 32'd0);
        return;
      end
      line1 = {a1[i], a0[i]};
      line2 = {b1[i], b0[i]};
      in_valid = 1'b1;
      if (cut_kind == 1 && i == cut_at) abort = 1'b1;
      if (perturb && i == 3) begin
        start = 1'b1;
        mode  = ~m;
      end
      tick();
      start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      if (cut_kind == 1 && i == cut_at) begin
        check({nm, "/abort_idle"}, 32'(busy), 32'd0);
        check({nm, "/abort_oval"}, 32'(out_valid), 32'd0);
        repeat (3) tick();
        check({nm, "/abort_nodone"}, 32'(done_cnt), 32'd0);
        check({nm, "/abort_ovf"}, 32'(overflw), 32'd0);
        return;
      end
      if (i == stall_after) begin
        held_o = outp;
        repeat (stall_len) begin
          idle_tick();
          check({nm, "/stall_oval"}, 32'(out_valid), 32'd0);
          check({nm, "/stall_hold"}, 32'(outp), 32'(held_o));
        end
        gaps += stall_len;
      end
    end
    repeat (3) idle_tick();
    check({nm, "/done_cnt"}, 32'(done_cnt), 32'd1);
    check({nm, "/done_lat"}, 32'(done_cyc - start_cyc), 32'(9 + gaps));
    check({nm, "/oval_cnt"}, 32'(rx_n), 32'd8);
    check({nm, "/res0"}, 32'(rx[0]), 32'(e0[7:0]));
    check({nm, "/res1"}, 32'(rx[1]), 32'(e1[7:0]));
    check({nm, "/ovf"}, 32'(ovf_done), 32'({e1[8], e0[8]}));
    check({nm, "/ovf_hold"}, 32'(overflw), 32'({e1[8], e0[8]}));
    check({nm, "/idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; rx_n = 0; done_cnt = 0; done_cyc = 0;
    ovf_done = '0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    in_valid = 1'b0; line1 = '0; line2 = '0;
    #1;
    check("reset_outp", 32'(outp), 32'd0);
    check("reset_oval", 32'(out_valid), 32'd0);
    check("reset_ovf", 32'(overflw), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // in_valid in IDLE must not produce output.
    in_valid = 1'b1; line1 = 2'b11; line2 = 2'b01;
    tick();
    tick();
    check("idle_oval", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    frame("t1_add", 1'b0, 8'h5A, 8'hA5, 8'hFF, 8'h01, -1, 0, -1, 0, 1'b0, 1'b0);
    frame("t2_sub", 1'b1, 8'h10, 8'h20, 8'h30, 8'h30, -1, 0, -1, 0, 1'b0, 1'b0);
    frame("t3_stall", 1'b0, 8'h5A, 8'hA5, 8'hFF, 8'h01, 3, 3, -1, 0, 1'b0, 1'b0);
    frame("t4_abort", 1'b1, 8'h10, 8'h20, 8'h00, 8'h01, -1, 0, 5, 1, 1'b0, 1'b0);
    frame("t4_after", 1'b0, 8'hC3, 8'h7E, 8'h80, 8'h80, -1, 0, -1, 0, 1'b0, 1'b0);
    frame("t5_reset", 1'b0, 8'hFF, 8'hFF, 8'hAA, 8'h55, -1, 0, 6, 2, 1'b0, 1'b0);
    frame("t5_after", 1'b1, 8'h01, 8'h02, 8'h9C, 8'h1D, -1, 0, -1, 0, 1'b0, 1'b0);
    frame("t6_perturb", 1'b0, 8'hFF, 8'h01, 8'h12, 8'h34, -1, 0, -1, 0, 1'b1, 1'b0);
    frame("t6_abort_last", 1'b0, 8'hFF, 8'h01, 8'hFF, 8'hFF, -1, 0, 7, 1, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      frame("rand", 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            -1, 0, -1, 0, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
